// File: rtl/core_seq_pkg.sv
// core_seq_pkg
//   Shared definitions for the core layer sequencer: sequencer state encoding,
//   bit positions inside core's 34-bit instruction word, address widths and
//   the idle instruction word (both SRAMs deselected, nothing else asserted).
package core_seq_pkg;

   localparam int INST_W  = 34;
   localparam int XADDR_W = 10;
   localparam int PADDR_W = 11;

   localparam int INST_LOAD      = 0;
   localparam int INST_EXEC      = 1;
   localparam int INST_L0_WR     = 2;
   localparam int INST_L0_RD     = 3;
   localparam int INST_OFIFO_RD  = 6;
   localparam int INST_XADDR_LSB = 7;
   localparam int INST_L0_SEL    = 17;
   localparam int INST_WEN_X     = 18;
   localparam int INST_CEN_X     = 19;
   localparam int INST_PADDR_LSB = 20;
   localparam int INST_WEN_P     = 31;
   localparam int INST_CEN_P     = 32;
   localparam int INST_ACCUM     = 33;

   // CEN/WEN are active-low, so the quiet word keeps all four high.
   localparam logic [INST_W-1:0] IDLE_INST =
      (INST_W'(1) << INST_CEN_X) | (INST_W'(1) << INST_WEN_X) |
      (INST_W'(1) << INST_CEN_P) | (INST_W'(1) << INST_WEN_P);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WFILL = 3'd1,
      ST_KLOAD = 3'd2,
      ST_KSET  = 3'd3,
      ST_XFILL = 3'd4,
      ST_EXEC  = 3'd5,
      ST_DRAIN = 3'd6,
      ST_DONE  = 3'd7
   } seq_state_e;

endpackage

// File: rtl/core_seq_if.sv
// core_seq_if
//   Bundle between the host/core side and the layer sequencer.
//   Host -> seq : start, w_base, x_base, p_base, x_len, accum_en
//   Core -> seq : ofifo_valid
//   Seq -> core : inst (34-bit instruction word)
//   Seq -> host : busy, done
//   master = host/core side, slave = sequencer.
interface core_seq_if #(
   parameter int len_bw = 10
);
   import core_seq_pkg::*;

   logic                start;
   logic [XADDR_W-1:0]  w_base;
   logic [XADDR_W-1:0]  x_base;
   logic [PADDR_W-1:0]  p_base;
   logic [len_bw-1:0]   x_len;
   logic                accum_en;
   logic                ofifo_valid;
   logic [INST_W-1:0]   inst;
   logic                busy;
   logic                done;

   modport master (
      output start, w_base, x_base, p_base, x_len, accum_en, ofifo_valid,
      input  inst, busy, done
   );

   modport slave (
      input  start, w_base, x_base, p_base, x_len, accum_en, ofifo_valid,
      output inst, busy, done
   );

endinterface

// File: rtl/core_seq.sv
// core_seq
//   Layer sequencer for one kernel tile of core: fills L0 with kernel words
//   from xmem, loads the kernel into the PE array, lets it settle, fills L0
//   with activations, executes, then drains the OFIFO into pmem (optionally
//   read-modify-write accumulating). Every inst bit is registered.
// Ports
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-low reset
//   bus    : core_seq_if.slave (host fields, ofifo_valid in; inst/busy/done out)
// Parameters
//   row    : PE rows, part of the kernel settle time
//   col    : PE cols, number of kernel words per tile
//   len_bw : width of x_len
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; inputs latched on accept
// ST_WFILL | col xmem reads of kernel words at w_base+idx
// ST_KLOAD | 1 l0_wr tail cycle, then col cycles load kernel + l0_rd
// ST_KSET  | row+col quiet cycles while the kernel settles in the array
// ST_XFILL | x_len xmem reads of activations at x_base+idx, then tail
// ST_EXEC  | x_len cycles execute + l0_rd
// ST_DRAIN | per output row: phase A ofifo_rd (+pmem read), phase B write
// ST_DONE  | done pulse, busy drops, back to idle
module core_seq
   import core_seq_pkg::*;
#(
   parameter int row    = 4,
   parameter int col    = 8,
   parameter int len_bw = 10
) (
   input  logic       clk,
   input  logic       reset,
   core_seq_if.slave  bus
);

   // One extra bit so XFILL can hold x_len reads plus its tail.
   localparam int CNT_W = len_bw + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   seq_state_e         state, state_nxt;

   logic [CNT_W-1:0]   tmr;        // cycles/slots left in state, terminal at 0
   logic [CNT_W-1:0]   idx;        // address offset within state
   logic [CNT_W-1:0]   tmr_load;
   logic               ph;         // DRAIN slot phase: 0 = A, 1 = B
   logic               tmr_tc;

   logic [XADDR_W-1:0] w_q, x_q;
   logic [PADDR_W-1:0] p_q;
   logic [len_bw-1:0]  len_q;
   logic               acc_q;

   logic [INST_W-1:0]  inst_q, inst_nxt;
   logic               busy_q, busy_nxt;
   logic               done_q, done_nxt;
   logic               accept;

   assign tmr_tc = (tmr == '0);
   assign accept = (state == ST_IDLE) && bus.start;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (accept && (bus.x_len != '0)) state_nxt = ST_WFILL;
         ST_WFILL: if (tmr_tc) state_nxt = ST_KLOAD;
         ST_KLOAD: if (tmr_tc) state_nxt = ST_KSET;
         ST_KSET:  if (tmr_tc) state_nxt = ST_XFILL;
         ST_XFILL: if (tmr_tc) state_nxt = ST_EXEC;
         ST_EXEC:  if (tmr_tc) state_nxt = ST_DRAIN;
         ST_DRAIN: if (ph && tmr_tc) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Timer reload value for the state being entered (length - 1).
   // KLOAD and XFILL carry one extra cycle for the l0_wr tail.
   always_comb begin
      tmr_load = '0;
      unique case (state_nxt)
         ST_WFILL:          tmr_load = CNT_W'(col - 1);
         ST_KLOAD:          tmr_load = CNT_W'(col);
         ST_KSET:           tmr_load = CNT_W'(row + col - 1);
         ST_XFILL:          tmr_load = CNT_W'(len_q);
         ST_EXEC, ST_DRAIN: tmr_load = CNT_W'(len_q) - CNT_ONE;
         default:           tmr_load = '0;
      endcase
   end

   // Counters are reloaded on every state change; in DRAIN they only step
   // at the end of a slot (phase B), and phase A waits on ofifo_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr <= '0;
         idx <= '0;
         ph  <= 1'b0;
      end else if (state_nxt != state) begin
         tmr <= tmr_load;
         idx <= '0;
         ph  <= 1'b0;
      end else if (state == ST_DRAIN) begin
         if (ph) begin
            tmr <= tmr - CNT_ONE;
            idx <= idx + CNT_ONE;
            ph  <= 1'b0;
         end else if (bus.ofifo_valid) begin
            ph  <= 1'b1;
         end
      end else if (state != ST_IDLE) begin
         tmr <= tmr - CNT_ONE;
         idx <= idx + CNT_ONE;
      end
   end

   // Tile parameters are captured only at accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_q   <= '0;
         x_q   <= '0;
         p_q   <= '0;
         len_q <= '0;
         acc_q <= 1'b0;
      end else if (accept) begin
         w_q   <= bus.w_base;
         x_q   <= bus.x_base;
         p_q   <= bus.p_base;
         len_q <= bus.x_len;
         acc_q <= bus.accum_en;
      end
   end

   // output logic
   always_comb begin
      inst_nxt = IDLE_INST;
      // xmem read data lands one cycle after the strobe, so l0_wr simply
      // follows the registered CEN_x by one cycle in every state.
      inst_nxt[INST_L0_WR] = ~inst_q[INST_CEN_X];
      unique case (state)
         ST_WFILL: begin
            inst_nxt[INST_CEN_X] = 1'b0;
            inst_nxt[INST_XADDR_LSB +: XADDR_W] = w_q + idx[XADDR_W-1:0];
         end
         ST_KLOAD: begin
            if (idx != '0) begin
               inst_nxt[INST_LOAD]  = 1'b1;
               inst_nxt[INST_L0_RD] = 1'b1;
            end
         end
         ST_XFILL: begin
            if (!tmr_tc) begin
               inst_nxt[INST_CEN_X] = 1'b0;
               inst_nxt[INST_XADDR_LSB +: XADDR_W] = x_q + idx[XADDR_W-1:0];
            end
         end
         ST_EXEC: begin
            inst_nxt[INST_EXEC]  = 1'b1;
            inst_nxt[INST_L0_RD] = 1'b1;
         end
         ST_DRAIN: begin
            if (!ph) begin
               if (bus.ofifo_valid) begin
                  inst_nxt[INST_OFIFO_RD] = 1'b1;
                  if (acc_q) begin
                     inst_nxt[INST_CEN_P] = 1'b0;
                     inst_nxt[INST_PADDR_LSB +: PADDR_W] = p_q + idx[PADDR_W-1:0];
                  end
               end
            end else begin
               inst_nxt[INST_CEN_P] = 1'b0;
               inst_nxt[INST_WEN_P] = 1'b0;
               inst_nxt[INST_ACCUM] = acc_q;
               inst_nxt[INST_PADDR_LSB +: PADDR_W] = p_q + idx[PADDR_W-1:0];
            end
         end
         default: ;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
      // A zero-length tile completes on the accept edge itself.
      done_nxt = (state == ST_DONE) || (accept && (bus.x_len == '0));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_q <= IDLE_INST;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         inst_q <= inst_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   assign bus.inst = inst_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq
//   Directed + randomized bench for core_seq. A tile is recorded cycle by
//   cycle and compared with a reference instruction stream assembled from
//   the tile phases (fill, load, settle, fill, execute, drain).
module tb_core_seq;

   localparam int ROW = 4;
   localparam int COL = 8;

   localparam int B_LOAD = 0,  B_EXEC = 1,  B_L0WR = 2,  B_L0RD = 3,  B_ORD = 6;
   localparam int B_XA   = 7,  B_WENX = 18, B_CENX = 19, B_PA   = 20;
   localparam int B_WENP = 31, B_CENP = 32, B_ACC  = 33;

   localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   cyc = 0;

   core_seq_if #(.len_bw(10)) bus ();

   core_seq #(.row(ROW), .col(COL), .len_bw(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] w_xrd(input logic [9:0] a);
      logic [33:0] w;
      w = IDLE_W;
      w[B_CENX] = 1'b0;
      w[B_XA +: 10] = a;
      return w;
   endfunction

   function automatic logic [33:0] w_prd(input logic [10:0] a);
      logic [33:0] w;
      w = IDLE_W;
      w[B_CENP] = 1'b0;
      w[B_PA +: 11] = a;
      w[B_ORD] = 1'b1;
      return w;
   endfunction

   function automatic logic [33:0] w_pwr(input logic [10:0] a, input logic acc);
      logic [33:0] w;
      w = IDLE_W;
      w[B_CENP] = 1'b0;
      w[B_WENP] = 1'b0;
      w[B_PA +: 11] = a;
      w[B_ACC] = acc;
      return w;
   endfunction

   // 0: always valid, 1: valid one cycle in three, 2: random
   function automatic logic next_valid(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 3) == 0;
      return ($urandom % 2) == 1;
   endfunction

   task automatic run_tile(input string tag, input logic [9:0] w, input logic [9:0] x,
                           input logic [10:0] p, input logic [9:0] len, input logic acc,
                           input int mode, input int restart_at);
      logic [33:0] tr[$];
      logic        vq[$];
      logic        dq[$];
      logic        bq[$];
      logic [33:0] ex[$];
      logic [33:0] tmp;
      logic        v;
      int n, k, ph, s, last, bad, fb, n_wr, bad_rd, bad_mix, bad_done, bad_busy;

      bus.w_base = w; bus.x_base = x; bus.p_base = p; bus.x_len = len; bus.accum_en = acc;
      bus.start = 1'b1;
      v = next_valid(mode);
      bus.ofifo_valid = v;
      @(posedge clk); #1; cyc++;
      bus.start = 1'b0;
      tr.push_back(bus.inst); vq.push_back(v); dq.push_back(bus.done); bq.push_back(bus.busy);
      n = 0;
      while (!bus.done && n < 4000) begin
         if (n == restart_at) begin
            bus.start  = 1'b1;
            bus.w_base = 10'($urandom);
            bus.x_base = 10'($urandom);
            bus.p_base = 11'($urandom);
            bus.x_len  = 10'd0;
         end else begin
            bus.start = 1'b0;
         end
         v = next_valid(mode);
         bus.ofifo_valid = v;
         @(posedge clk); #1; cyc++; n++;
         tr.push_back(bus.inst); vq.push_back(v); dq.push_back(bus.done); bq.push_back(bus.busy);
      end
      bus.start = 1'b0;
      chk({tag, " done reached"}, 64'(bus.done), 64'd1);

      // reference stream: quiet word at accept, then the tile phases
      ex.push_back(IDLE_W);
      for (int i = 0; i < COL; i++) ex.push_back(w_xrd(w + 10'(i)));
      ex.push_back(IDLE_W);
      for (int i = 0; i < COL; i++)
         ex.push_back(IDLE_W | (34'd1 << B_LOAD) | (34'd1 << B_L0RD));
      for (int i = 0; i < ROW + COL; i++) ex.push_back(IDLE_W);
      for (int i = 0; i < int'(len); i++) ex.push_back(w_xrd(x + 10'(i)));
      ex.push_back(IDLE_W);
      for (int i = 0; i < int'(len); i++)
         ex.push_back(IDLE_W | (34'd1 << B_EXEC) | (34'd1 << B_L0RD));
      // drain: each output row waits for valid, pops it, then writes pmem
      k = 0; ph = 0; s = ex.size();
      while (k < int'(len)) begin
         v = (s < tr.size()) ? vq[s] : 1'b1;
         if (ph == 0) begin
            if (v) begin
               ex.push_back(acc ? w_prd(p + 11'(k)) : (IDLE_W | (34'd1 << B_ORD)));
               ph = 1;
            end else begin
               ex.push_back(IDLE_W);
            end
         end else begin
            ex.push_back(w_pwr(p + 11'(k), acc));
            ph = 0;
            k++;
         end
         s++;
      end
      ex.push_back(IDLE_W);
      // SRAM read data is written into L0 the cycle after each read
      for (int i = 1; i < ex.size(); i++) begin
         if (!ex[i-1][B_CENX]) begin
            tmp = ex[i];
            tmp[B_L0WR] = 1'b1;
            ex[i] = tmp;
         end
      end

      chk({tag, " trace length"}, 64'(tr.size()), 64'(ex.size()));
      bad = 0; fb = -1;
      for (int i = 0; i < tr.size() && i < ex.size(); i++) begin
         if (tr[i] !== ex[i]) begin
            bad++;
            if (fb < 0) fb = i;
         end
      end
      chk($sformatf("%s inst words wrong (first at %0d)", tag, fb), 64'(bad), 64'd0);

      last = tr.size() - 1;
      n_wr = 0; bad_rd = 0; bad_mix = 0; bad_done = 0; bad_busy = 0;
      for (int i = 0; i < tr.size(); i++) begin
         if (!tr[i][B_CENP] && !tr[i][B_WENP]) n_wr++;
         if (tr[i][B_ORD] && !vq[i]) bad_rd++;
         if (tr[i][B_EXEC] && tr[i][B_LOAD]) bad_mix++;
         if (dq[i] !== (i == last)) bad_done++;
         if (bq[i] !== (i != last)) bad_busy++;
      end
      chk({tag, " pmem write count"}, 64'(n_wr), 64'(len));
      chk({tag, " ofifo_rd without valid"}, 64'(bad_rd), 64'd0);
      chk({tag, " exec with load"}, 64'(bad_mix), 64'd0);
      chk({tag, " done pulse shape"}, 64'(bad_done), 64'd0);
      chk({tag, " busy shape"}, 64'(bad_busy), 64'd0);
   endtask

   initial begin
      int n, extra;
      bus.start = 1'b0; bus.w_base = '0; bus.x_base = '0; bus.p_base = '0;
      bus.x_len = '0; bus.accum_en = 1'b0; bus.ofifo_valid = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset inst", 64'(bus.inst), 64'(IDLE_W));
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // reset in the middle of EXEC
      bus.w_base = 10'd0; bus.x_base = 10'd64; bus.p_base = 11'd0; bus.x_len = 10'd36;
      bus.accum_en = 1'b0; bus.ofifo_valid = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (!bus.inst[B_EXEC] && n < 500) begin
         @(posedge clk); #1; n++;
      end
      chk("exec reached", 64'(bus.inst[B_EXEC]), 64'd1);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mid-exec reset inst", 64'(bus.inst), 64'(IDLE_W));
      chk("mid-exec reset busy", 64'(bus.busy), 64'd0);
      chk("mid-exec reset done", 64'(bus.done), 64'd0);
      @(posedge clk); #1;
      chk("held reset inst", 64'(bus.inst), 64'(IDLE_W));
      reset = 1'b1;
      @(posedge clk); #1;

      run_tile("t2 overwrite",   10'd0,    10'd64,   11'd0,    10'd36, 1'b0, 0, -1);
      run_tile("t3 accumulate",  10'd0,    10'd64,   11'd0,    10'd36, 1'b1, 0, -1);
      run_tile("t4 valid 1of3",  10'd5,    10'd100,  11'd300,  10'd20, 1'b0, 1, -1);
      run_tile("t4 valid 1of3a", 10'd17,   10'd200,  11'd700,  10'd12, 1'b1, 1, -1);
      run_tile("t5 wrap",        10'd1022, 10'd1020, 11'd2044, 10'd8,  1'b0, 0, -1);
      run_tile("t5 wrap acc",    10'd1020, 10'd1020, 11'd2044, 10'd8,  1'b1, 2, -1);
      run_tile("t5 len 1",       10'd3,    10'd9,    11'd2047, 10'd1,  1'b1, 2, -1);
      for (int r = 0; r < 3; r++)
         run_tile($sformatf("rand%0d", r), 10'($urandom), 10'($urandom), 11'($urandom),
                  10'($urandom_range(1, 24)), 1'($urandom), 2, -1);

      // zero-length tile
      bus.x_len = 10'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("len0 done", 64'(bus.done), 64'd1);
      chk("len0 busy", 64'(bus.busy), 64'd0);
      chk("len0 inst", 64'(bus.inst), 64'(IDLE_W));
      @(posedge clk); #1;
      chk("len0 done drops", 64'(bus.done), 64'd0);
      chk("len0 inst quiet", 64'(bus.inst), 64'(IDLE_W));

      // start while busy is ignored, exactly one done
      run_tile("t6 restart", 10'd3, 10'd10, 11'd20, 10'd4, 1'b0, 0, 15);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy || (bus.inst !== IDLE_W)) extra++;
      end
      chk("t6 no second tile", 64'(extra), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
